pipelined_ripple_adder: RTL and testbench
=========================================

Name: pipelined_ripple_adder

Overview:
- Parametrised, pipelined successor to the 4-bit ripple-carry adder. Operands are split into CHUNK-bit slices; one slice is resolved per pipeline stage, and the carry is registered between stages.
- Supports add/subtract mode, a signed-overflow flag, and valid/ready flow control with full back-pressure.
- Serves as the wide adder/subtractor for datapath blocks that need a WIDTH above 4 at a clock rate a single ripple chain cannot meet.

Parameters:
- WIDTH, 16: operand/result width in bits. Must be a multiple of CHUNK and at least CHUNK.
- CHUNK, 4: bits resolved per pipeline stage. STAGES = WIDTH/CHUNK.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- X  input  WIDTH  operand A
- Y  input  WIDTH  operand B
- Cin  input  1  carry-in; borrow-not-in when Sub=1
- Sub  input  1  0: S = X + Y + Cin; 1: S = X + ~Y + Cin
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat this cycle
- S  output  WIDTH  result
- Cout  output  1  raw carry out of MSB
- Ovf  output  1  signed (two's-complement) overflow
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result

Behaviour:
- Only clk is used. All state is reset synchronously when rst_n=0 at a rising edge.
- Reset values: S=0, Cout=0, Ovf=0, out_valid=0, all internal stage valids=0, all stage data=0. in_ready=1 in the first cycle after reset.
- Global advance: adv = !out_valid || out_ready. in_ready = adv, a combinational function of registered out_valid and out_ready. in_ready must not depend on in_valid.
- Input acceptance: a beat is accepted when in_valid && in_ready. When adv=0, the whole pipeline holds, including bubbles.
- Stage k (0..STAGES-1):
  - Adds slice k of X with slice k of (Sub ? ~Y : Y), plus the carry from stage k-1 (Cin for k=0).
  - Registers the CHUNK sum bits, the carry, and the still-unprocessed upper operand slices.
  - Lower result slices are carried forward unchanged.
- Effective Y inversion is applied at input capture. Sub is not stored past stage 0.
- Latency: exactly STAGES cycles from acceptance to out_valid (4 for defaults), provided out_ready stays 1. Throughput is one beat per cycle.
- Bubbles (in_valid=0 while adv=1) propagate as invalid stages. out_valid reflects only the final stage valid.
- Output stall: while out_valid && !out_ready, S/Cout/Ovf/out_valid hold stable. Upstream stages also hold, so no beat is lost or duplicated.
- Same-cycle events:
  - Output consumed and new input accepted in the same cycle: both take effect; the pipeline shifts by one.
  - in_valid=1 with in_ready=0: beat not taken. The source must hold it.
- Ovf = (X[MSB] == Yeff[MSB]) && (S[MSB] != X[MSB]), where Yeff = Sub ? ~Y : Y, computed in the final stage.
- Cout is the unsigned carry out of bit WIDTH-1. For Sub=1, Cin=1, Cout=1 means no borrow (X >= Y unsigned).
- Wrap-around: results are modulo 2^WIDTH. There is no saturation unless the optional feature is enabled.
- Reset mid-operation: all in-flight beats are discarded. out_valid=0 on the cycle after the reset edge, and no stale result appears afterwards.
- STAGES=1 (WIDTH==CHUNK) is legal: a single registered ripple adder with latency 1.

Optional Feature:
- Macro: PIPELINED_RIPPLE_ADDER_SAT_EN.
- Defined: when Ovf=1 in the final stage, S is replaced by the signed limit. A positive overflow (X[MSB]=0) gives 0111...1; a negative overflow gives 1000...0. Ovf and Cout still report the raw values. Latency is unchanged.
- Undefined: S is the wrapped modulo result; no saturation logic is present.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 cycles, then release. Required: S=0, Cout=0, Ovf=0, out_valid=0, in_ready=1.
- Basic add: WIDTH=16, CHUNK=4, out_ready=1. Send X=0x1234, Y=0x0FCC, Cin=0, Sub=0. Required, exactly 4 cycles later: S=0x2200, Cout=0, Ovf=0, out_valid=1 for one cycle.
- Full carry ripple across all stages: X=0xFFFF, Y=0x0000, Cin=1. Required: S=0x0000, Cout=1, Ovf=0.
- Subtract and overflow:
  - X=0x0005, Y=0x0007, Sub=1, Cin=1. Required: S=0xFFFE, Cout=0, Ovf=0.
  - X=0x7FFF, Y=0x0001, Sub=0, Cin=0. Required: S=0x8000, Ovf=1, or S=0x7FFF with Ovf=1 when PIPELINED_RIPPLE_ADDER_SAT_EN is defined.
- Back-pressure and streaming:
  - Stream 8 back-to-back beats (X=i, Y=i, i=1..8) with out_ready toggling 1,0,0,1 repeatedly.
  - Required: outputs 2,4,...,16 appear in order with no loss or duplication. S is stable while stalled, and in_ready=0 whenever out_valid && !out_ready.
- Reset mid-flight: accept 3 beats, assert rst_n=0 for 1 cycle, then release. Required: out_valid stays 0 until a new beat is accepted; the next result appears 4 cycles after acceptance.

Source files
------------

// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder
// Parametrised pipelined ripple-carry adder/subtractor. Each pipeline stage
// resolves one CHUNK-bit slice and registers the carry between stages. All
// stages advance together under a single advance signal, so back-pressure at
// the output freezes the whole pipe, including bubbles.
//
// Optional feature macro: PIPELINED_RIPPLE_ADDER_SAT_EN
//   defined   -> on signed overflow the result saturates to the signed limit
//   undefined -> result wraps modulo 2^WIDTH
module pipelined_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic             Sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;
    localparam int MSB    = WIDTH - 1;

    // Stage registers: operands travel with the beat so later stages can
    // consume their slices; the running sum collects resolved slices.
    logic [WIDTH-1:0] r_x   [STAGES];
    logic [WIDTH-1:0] r_y   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic             r_c   [STAGES];
    logic             r_v   [STAGES];
    logic             r_ovf;

    // Next-state values produced by each stage's combinational slice adder
    logic [WIDTH-1:0] w_x_nx   [STAGES];
    logic [WIDTH-1:0] w_y_nx   [STAGES];
    logic [WIDTH-1:0] w_sum_nx [STAGES];
    logic             w_c_nx   [STAGES];
    logic             w_v_nx   [STAGES];

    logic [WIDTH-1:0] w_yeff;
    logic [WIDTH-1:0] w_final_sum;
    logic             w_ovf;
    logic             w_adv;

    // The whole pipe moves when the output slot is empty or being drained
    assign w_adv    = !r_v[LAST] || out_ready;
    assign in_ready = w_adv;

    // Subtraction is folded into the operand once, at capture; Sub is not
    // carried further down the pipe.
    assign w_yeff = Sub ? ~Y : Y;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] w_x_in;
        logic [WIDTH-1:0] w_y_in;
        logic [WIDTH-1:0] w_sum_in;
        logic [WIDTH-1:0] w_sum_loc;
        logic             w_c_in;
        logic             w_v_in;
        logic [CHUNK:0]   w_slice;

        if (k == 0) begin : g_first
            assign w_x_in   = X;
            assign w_y_in   = w_yeff;
            assign w_c_in   = Cin;
            assign w_sum_in = {WIDTH{1'b0}};
            assign w_v_in   = in_valid;
        end else begin : g_next
            assign w_x_in   = r_x[k-1];
            assign w_y_in   = r_y[k-1];
            assign w_c_in   = r_c[k-1];
            assign w_sum_in = r_sum[k-1];
            assign w_v_in   = r_v[k-1];
        end

        // CHUNK-bit ripple slice with carry-in from the previous stage
        assign w_slice = {1'b0, w_x_in[k*CHUNK +: CHUNK]}
                       + {1'b0, w_y_in[k*CHUNK +: CHUNK]}
                       + {{CHUNK{1'b0}}, w_c_in};

        // Insert this stage's slice; lower slices pass through untouched
        always_comb begin
            w_sum_loc                    = w_sum_in;
            w_sum_loc[k*CHUNK +: CHUNK]  = w_slice[CHUNK-1:0];
        end

        assign w_x_nx[k]   = w_x_in;
        assign w_y_nx[k]   = w_y_in;
        assign w_sum_nx[k] = w_sum_loc;
        assign w_c_nx[k]   = w_slice[CHUNK];
        assign w_v_nx[k]   = w_v_in;
    end

    // Signed overflow: operands agree in sign but the result does not
    assign w_ovf = (w_x_nx[LAST][MSB] == w_y_nx[LAST][MSB]) &&
                   (w_sum_nx[LAST][MSB] != w_x_nx[LAST][MSB]);

`ifdef PIPELINED_RIPPLE_ADDER_SAT_EN
    // Clamp an overflowing result to the signed limit in the operand's sign
    always_comb begin
        w_final_sum = w_sum_nx[LAST];
        if (w_ovf) begin
            if (w_x_nx[LAST][MSB]) begin
                w_final_sum      = {WIDTH{1'b0}};
                w_final_sum[MSB] = 1'b1;
            end else begin
                w_final_sum      = {WIDTH{1'b1}};
                w_final_sum[MSB] = 1'b0;
            end
        end else begin
            w_final_sum = w_sum_nx[LAST];
        end
    end
`else
    assign w_final_sum = w_sum_nx[LAST];
`endif

    // Pipeline registers: synchronous clear, otherwise shift on advance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_x[k]   <= {WIDTH{1'b0}};
                r_y[k]   <= {WIDTH{1'b0}};
                r_sum[k] <= {WIDTH{1'b0}};
                r_c[k]   <= 1'b0;
                r_v[k]   <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_x[k] <= w_x_nx[k];
                r_y[k] <= w_y_nx[k];
                r_c[k] <= w_c_nx[k];
                r_v[k] <= w_v_nx[k];
                if (k == LAST) begin
                    r_sum[k] <= w_final_sum;
                end else begin
                    r_sum[k] <= w_sum_nx[k];
                end
            end
            r_ovf <= w_ovf;
        end
    end

    assign S         = r_sum[LAST];
    assign Cout      = r_c[LAST];
    assign Ovf       = r_ovf;
    assign out_valid = r_v[LAST];

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed self-checking bench for pipelined_ripple_adder (WIDTH=16, CHUNK=4).
module tb_pipelined_ripple_adder;

    logic        clk;
    logic        rst_n;
    logic [15:0] X;
    logic [15:0] Y;
    logic        Cin;
    logic        Sub;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] S;
    logic        Cout;
    logic        Ovf;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    pipelined_ripple_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .X         (X),
        .Y         (Y),
        .Cin       (Cin),
        .Sub       (Sub),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .Cout      (Cout),
        .Ovf       (Ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Free-running clock, 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Send one beat into an idle pipe and verify exact latency and values.
    // Called and returns #1 after a rising edge.
    task automatic run_beat(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic cin, input logic sub,
                            input logic [15:0] es, input logic ec, input logic eo);
        X = x; Y = y; Cin = cin; Sub = sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_s"},     32'(S),         32'(es));
        chk({tag, "_cout"},  32'(Cout),      32'(ec));
        chk({tag, "_ovf"},   32'(Ovf),       32'(eo));
        @(posedge clk); #1;
        chk({tag, "_one_cycle"}, 32'(out_valid), 32'd0);
    endtask

    logic [15:0] ovf_exp_s;
    bit   [3:0]  pat;
    int          beat_idx;
    int          n_out;
    int          cyc;
    logic        stalled;
    logic [15:0] held_s;

    initial begin
        rst_n = 1'b0; X = 16'h0000; Y = 16'h0000; Cin = 1'b0; Sub = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;

        // Reset / idle
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_s",         32'(S),         32'd0);
        chk("rst_cout",      32'(Cout),      32'd0);
        chk("rst_ovf",       32'(Ovf),       32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        // Directed single beats
        run_beat("add",    16'h1234, 16'h0FCC, 1'b0, 1'b0, 16'h2200, 1'b0, 1'b0);
        run_beat("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_beat("sub",    16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_beat("sub_ge", 16'h0009, 16'h0004, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0);
`ifdef PIPELINED_RIPPLE_ADDER_SAT_EN
        ovf_exp_s = 16'h7FFF;
`else
        ovf_exp_s = 16'h8000;
`endif
        run_beat("ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, ovf_exp_s, 1'b0, 1'b1);

        // Streaming with out_ready pattern 1,0,0,1
        pat = 4'b1001;
        beat_idx = 0; n_out = 0; cyc = 0; stalled = 1'b0; held_s = 16'h0000;
        Cin = 1'b0; Sub = 1'b0;
        while (n_out < 8 && cyc < 200) begin
            @(posedge clk); #1;
            if (stalled) begin
                chk("stall_hold_s",     32'(S),         32'(held_s));
                chk("stall_hold_valid", 32'(out_valid), 32'd1);
            end
            out_ready = pat[cyc % 4];
            in_valid  = (beat_idx < 8);
            X = 16'(beat_idx + 1);
            Y = 16'(beat_idx + 1);
            #1;
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", 32'(in_ready), 32'd0);
            end else begin
                chk("flow_in_ready", 32'(in_ready), 32'd1);
            end
            if (out_valid && out_ready) begin
                chk("stream_s", 32'(S), 32'(2 * (n_out + 1)));
                n_out++;
            end
            stalled = out_valid && !out_ready;
            held_s  = S;
            if (in_valid && in_ready) beat_idx++;
            cyc++;
        end
        chk("stream_count", 32'(n_out), 32'd8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("stream_drained", 32'(out_valid), 32'd0);

        // Reset mid-flight: three beats in, then a one-cycle reset
        for (int i = 0; i < 3; i++) begin
            X = 16'(16'h0100 + i); Y = 16'h0001; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_valid_after_edge", 32'(out_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_stale", 32'(out_valid), 32'd0);
        end
        run_beat("post_rst", 16'h0100, 16'h0023, 1'b0, 1'b0, 16'h0123, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
